// File: rtl/pocket_bridge_pkg.sv
// Shared definitions for the Pocket bridge SPI master.
//   - Opcode bytes for write/read frames.
//   - Frame field widths.
//   - Master state enumeration (ST_ACK only reachable when
//     POCKET_BRIDGE_ACKWAIT_EN is defined).
package pocket_bridge_pkg;

    localparam int unsigned OPC_W   = 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FRAME_W = OPC_W + ADDR_W + DATA_W;

    localparam logic [OPC_W-1:0] BRG_OP_WR = 8'h01;
    localparam logic [OPC_W-1:0] BRG_OP_RD = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_OPC,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_ACK,
        ST_HOLD,
        ST_DONE
    } brg_state_e;

endpackage

// File: rtl/pocket_bridge_sclk.sv
// Half-period divider for the bridge serial clock.
// Ports:
//   clk_i, rst_ni : system clock, synchronous active-low reset
//   en_i          : counter runs while high; cleared (and sclk low) when low
//   run_i         : allow sclk to toggle on counter wrap
//   tick_o        : counter wrap strobe (DIV cycles elapsed)
//   rise_o/fall_o : wrap strobes on which sclk goes high / low
//   sclk_o        : serial clock level, idle low
module pocket_bridge_sclk #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic run_i,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        wrap   = en_i && (cnt_q == CW'(DIV - 1));
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            if (run_i) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign tick_o = wrap;
    assign rise_o = wrap && run_i && !sclk_q;
    assign fall_o = wrap && run_i && sclk_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/pocket_bridge_master.sv
// Bridge SPI master: turns 32-bit read/write commands into serial
// bridge frames (opcode, address, data / turnaround + read data).
// Optional macro POCKET_BRIDGE_ACKWAIT_EN adds a write-ack wait state
// with a TIMEOUT parameter; without it rsp_err is tied low.
// Ports:
//   clk, rst_n            : system clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_wr, cmd_addr,
//   cmd_wdata             : command fields, latched on acceptance
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata             : read data (0 after writes)
//   rsp_err               : write-ack timeout
//   spimosi/spimiso       : serial data out / in
//   spiclk, spiss         : serial clock (idle low), select (active low)
module pocket_bridge_master
    import pocket_bridge_pkg::*;
#(
    parameter int unsigned DIV  = 2,
    parameter int unsigned TURN = 4
`ifdef POCKET_BRIDGE_ACKWAIT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        spimosi,
    input  logic        spimiso,
    output logic        spiclk,
    output logic        spiss
);

    brg_state_e         state_q, state_d;
    logic [5:0]         bits_q, bits_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               is_rd_q, is_rd_d;

    logic sclk_en, sclk_run, tick, rise, fall, last_fall;

`ifdef POCKET_BRIDGE_ACKWAIT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_q, to_d;
    logic            ackd_q, ackd_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        sclk_en  = (state_q != ST_IDLE) && (state_q != ST_DONE);
        sclk_run = (state_q == ST_OPC)   || (state_q == ST_ADDR)  ||
                   (state_q == ST_WDATA) || (state_q == ST_TURN)  ||
                   (state_q == ST_RDATA) || (state_q == ST_ACK);
    end

    pocket_bridge_sclk #(
        .DIV (DIV)
    ) u_sclk (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (sclk_en),
        .run_i  (sclk_run),
        .tick_o (tick),
        .rise_o (rise),
        .fall_o (fall),
        .sclk_o (spiclk)
    );

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        is_rd_d = is_rd_q;
`ifdef POCKET_BRIDGE_ACKWAIT_EN
        to_d    = to_q;
        ackd_d  = ackd_q;
        err_d   = err_q;
`endif
        last_fall = fall && (bits_q == 6'd1);

        // The whole frame lives in one shift register; its MSB is spimosi,
        // so mosi advances on every falling edge and zeros fill in behind.
        if (fall) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            if (bits_q != 6'd1) begin
                bits_d = bits_q - 6'd1;
            end
        end
        if (rise && (state_q == ST_RDATA)) begin
            rx_d = {rx_q[DATA_W-2:0], spimiso};
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    is_rd_d = !cmd_wr;
                    tx_d    = {cmd_wr ? BRG_OP_WR : BRG_OP_RD, cmd_addr,
                               cmd_wr ? cmd_wdata : '0};
                    bits_d  = 6'(OPC_W);
                    state_d = ST_SETUP;
`ifdef POCKET_BRIDGE_ACKWAIT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_OPC;
                end
            end
            ST_OPC: begin
                if (last_fall) begin
                    state_d = ST_ADDR;
                    bits_d  = 6'(ADDR_W);
                end
            end
            ST_ADDR: begin
                if (last_fall) begin
                    bits_d = 6'(DATA_W);
                    if (!is_rd_q) begin
                        state_d = ST_WDATA;
                    end else if (TURN == 0) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_TURN;
                        bits_d  = 6'(TURN);
                    end
                end
            end
            ST_WDATA: begin
                if (last_fall) begin
`ifdef POCKET_BRIDGE_ACKWAIT_EN
                    state_d = ST_ACK;
                    to_d    = '0;
                    ackd_d  = 1'b0;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
            ST_TURN: begin
                if (last_fall) begin
                    state_d = ST_RDATA;
                    bits_d  = 6'(DATA_W);
                end
            end
            ST_RDATA: begin
                if (last_fall) begin
                    state_d = ST_HOLD;
                end
            end
`ifdef POCKET_BRIDGE_ACKWAIT_EN
            ST_ACK: begin
                // Ack seen on a rise ends the wait at that period's fall.
                if (rise && spimiso) begin
                    ackd_d = 1'b1;
                end
                if (fall) begin
                    if (ackd_q) begin
                        state_d = ST_HOLD;
                    end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = ST_HOLD;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
`endif
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_DONE;
                    rdata_d = is_rd_q ? rx_q : '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            is_rd_q <= 1'b0;
`ifdef POCKET_BRIDGE_ACKWAIT_EN
            to_q    <= '0;
            ackd_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            is_rd_q <= is_rd_d;
`ifdef POCKET_BRIDGE_ACKWAIT_EN
            to_q    <= to_d;
            ackd_q  <= ackd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign spimosi   = tx_q[FRAME_W-1];
    assign spiss     = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef POCKET_BRIDGE_ACKWAIT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/pocket_bridge_master.md
Name: pocket_bridge_master

Overview:
- Simulation/test-side SPI bridge master that sits directly upstream of the Pocket core's bridge port.
- Drives bridge_spimosi, bridge_spiclk and bridge_spiss, and samples bridge_spimiso.
- Turns queued 32-bit read/write commands from the bench (ROM download, register pokes, status polls) into serial bridge transactions.
- Returns read data on a response channel.

Parameters:
- DIV, 2, clk cycles per spiclk half-period (legal ≥1).
- TURN, 4, idle spiclk periods between address and read data.
- TIMEOUT, 64, spiclk periods to wait for write ack (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle, accepts command.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  32  bridge address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse, transaction complete.
- rsp_rdata  out  32  read data (0 after writes).
- rsp_err  out  1  ack timeout (0 unless optional feature).
- spimosi  out  1  serial data to core.
- spimiso  in  1  serial data from core.
- spiclk  out  1  serial clock, idle low.
- spiss  out  1  select, active low.

Behaviour:
- Reset (rst_n low at a clk edge): cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, spimosi=0, spiclk=0, spiss=1, state IDLE. Reset mid-transaction aborts immediately; no rsp_valid.
- Handshake: command accepted when cmd_valid & cmd_ready at a clk edge. Fields are latched; cmd_ready drops the next cycle and stays 0 until the cycle after rsp_valid.
- Frame, MSB first:
  - opcode byte (0x01 write, 0x02 read);
  - 32-bit address;
  - write: 32-bit data; read: TURN idle periods with mosi=0, then 32 bits sampled from miso.
- Bit timing: half-period counter counts 0..DIV-1.
  - spiclk toggles when the counter wraps.
  - spimosi updates on the clk edge that drives spiclk low (and at frame start).
  - spimiso is sampled on the clk edge that drives spiclk high.
- States:
  - IDLE: spiss=1.
  - SETUP: spiss=0, first opcode bit on mosi, held DIV cycles.
  - OPC: 8 bits.
  - ADDR: 32 bits.
  - WDATA: 32 bits.
  - TURN: TURN periods.
  - RDATA: 32 bits.
  - ACK: optional feature only.
  - HOLD: spiclk low, DIV cycles.
  - DONE: spiss=1, rsp_valid=1 for one cycle, then IDLE.
- Bit counter is 6 bits, reloaded per state; a state exits after its last falling edge.
- Transaction length in clk cycles: write = 2·DIV·72 + 2·DIV + 1; read = 2·DIV·(40+TURN+32) + 2·DIV + 1.
- rsp_rdata is updated only for reads and holds until the next response.
- spiss deasserts for at least one clk cycle between back-to-back transactions.
- cmd_valid held high continuously gives back-to-back transactions without loss.

Optional Feature:
- POCKET_BRIDGE_ACKWAIT_EN defined: after WDATA, the master enters ACK and keeps clocking spiclk with mosi=0.
  - spimiso=1 sampled on a rising edge ends the wait with rsp_err=0.
  - TIMEOUT periods with no ack set rsp_err=1 alongside rsp_valid.
  - Reads are unaffected.
- Undefined: no ACK state; rsp_err is tied 0.

Decomposition:
- Package pocket_bridge_pkg: opcode constants (BRG_OP_WR=8'h01, BRG_OP_RD=8'h02), state enumeration, frame field widths (OPC_W=8, ADDR_W=32, DATA_W=32).
- One sub-module is natural: pocket_bridge_sclk, the half-period divider producing rise/fall strobes and the spiclk level.

Test Plan:
- Reset released, no command → cmd_ready=1, spiss=1, spiclk=0, spimosi=0 held for 100 cycles.
- Write addr 0x0000_1234, data 0xDEAD_BEEF, DIV=2 → slave model captures 0x01, 0x00001234, 0xDEADBEEF; rsp_valid after 293 cycles; rsp_rdata=0.
- Read addr 0xF800_0000, slave drives 0xCAFE_F00D after TURN=4 periods → rsp_rdata=0xCAFEF00D, rsp_err=0, one-cycle rsp_valid.
- Three back-to-back commands with cmd_valid held high → three responses in order; spiss high ≥1 cycle between frames.
- rst_n low at bit 20 of the address phase → next cycle spiss=1, spiclk=0, no rsp_valid; the following command completes normally.
- With POCKET_BRIDGE_ACKWAIT_EN and no ack from the slave, TIMEOUT=64 → rsp_err=1 after 64 spiclk periods; with ack on the 3rd period → rsp_err=0.
